// File: rtl/jogo_pkg.sv
// Player codes, board constants and sequencer states shared by the move controller.
package jogo_pkg;
  localparam logic [1:0] VAZIO      = 2'b00;
  localparam logic [1:0] JOG1       = 2'b01;
  localparam logic [1:0] JOG2       = 2'b10;
  localparam logic [1:0] EMPATE     = 2'b11;
  localparam logic [3:0] META_MACRO = 4'd0;

  typedef enum logic [3:0] {
    LIMPA, OCIOSO, LE, CONFERE, ESCREVE, ESPERA, AMOSTRA_MICRO,
    ESCREVE_META, ESPERA_META, AMOSTRA_META, PROX_END, PROX_AMOSTRA,
    FIM, FIMJOGO, REJEITA
  } estado_t;

  function automatic logic pos_valida(input logic [3:0] p);
    return (p >= 4'd1) && (p <= 4'd9);
  endfunction

  // A board is decided once it holds a winner or is drawn.
  function automatic logic decidido(input logic [1:0] s);
    return (s == JOG1) || (s == JOG2) || (s == EMPATE);
  endfunction

  function automatic logic [1:0] outro_jogador(input logic [1:0] j);
    return (j == JOG1) ? JOG2 : JOG1;
  endfunction
endpackage

// File: rtl/contador_limpeza.sv
// Clear-sweep counter: walks board cells 0..N-1 as (macro, micro) decimal digits.
module contador_limpeza #(
  parameter int N = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] macro,
  output logic [3:0] micro,
  output logic       fim
);
  localparam logic [6:0] ULTIMO = 7'(N - 1);

  logic [6:0] cnt_q, cnt_d;
  logic [3:0] macro_q, macro_d;
  logic [3:0] micro_q, micro_d;

  always_comb begin
    cnt_d   = cnt_q;
    macro_d = macro_q;
    micro_d = micro_q;
    if (clr || (en && cnt_q == ULTIMO)) begin
      cnt_d   = 7'd0;
      macro_d = 4'd0;
      micro_d = 4'd0;
    end else if (en) begin
      cnt_d = cnt_q + 7'd1;
      if (micro_q == 4'd9) begin
        micro_d = 4'd0;
        macro_d = macro_q + 4'd1;
      end else begin
        micro_d = micro_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 7'd0;
      macro_q <= 4'd0;
      micro_q <= 4'd0;
    end else begin
      cnt_q   <= cnt_d;
      macro_q <= macro_d;
      micro_q <= micro_d;
    end
  end

  assign macro = macro_q;
  assign micro = micro_q;
  assign fim   = (cnt_q == ULTIMO);
endmodule

// File: rtl/controle_jogada.sv
// Move sequencer for ultimate tic-tac-toe: owns the board RAM port, clears it,
// validates and commits moves, tracks the meta-board and the forced macro cell.
module controle_jogada
  import jogo_pkg::*;
#(
  parameter logic [1:0] JOGADOR_INICIAL = 2'b01,
  parameter int         N_LIMPA         = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogar,
  input  logic [3:0] macro_in,
  input  logic [3:0] micro_in,
  output logic       ram_we,
  output logic [1:0] ram_data,
  output logic [3:0] ram_addr_macro,
  output logic [3:0] ram_addr_micro,
  input  logic [1:0] ram_q,
  input  logic [1:0] ram_state,
  output logic       pronto,
  output logic       jogada_ok,
  output logic       jogada_invalida,
  output logic [1:0] jogador_vez,
  output logic       macro_livre,
  output logic [3:0] macro_atual,
  output logic       fim_jogo,
  output logic [1:0] vencedor
);
  estado_t    state_q, state_d;
  logic [3:0] macro_l_q, macro_l_d, micro_l_q, micro_l_d;
  logic [1:0] jog_l_q, jog_l_d;
  logic       ram_we_q, ram_we_d;
  logic [1:0] ram_data_q, ram_data_d;
  logic [3:0] ram_addr_macro_q, ram_addr_macro_d, ram_addr_micro_q, ram_addr_micro_d;
  logic       pronto_q, pronto_d, jogada_ok_q, jogada_ok_d, jogada_invalida_q, jogada_invalida_d;
  logic [1:0] jogador_vez_q, jogador_vez_d, vencedor_q, vencedor_d;
  logic       macro_livre_q, macro_livre_d, fim_jogo_q, fim_jogo_d;
  logic [3:0] macro_atual_q, macro_atual_d;

  logic       cnt_en;
  logic [3:0] cnt_macro, cnt_micro;
  logic       cnt_fim;

  contador_limpeza #(.N(N_LIMPA)) u_contador (
    .clk   (clk),
    .rst   (reset),
    .clr   (iniciar),
    .en    (cnt_en),
    .macro (cnt_macro),
    .micro (cnt_micro),
    .fim   (cnt_fim)
  );

  // RAM controls are registered: each state sets up the port for the state it enters.
  always_comb begin
    state_d           = state_q;
    macro_l_d         = macro_l_q;
    micro_l_d         = micro_l_q;
    jog_l_d           = jog_l_q;
    ram_we_d          = 1'b0;
    ram_data_d        = VAZIO;
    ram_addr_macro_d  = ram_addr_macro_q;
    ram_addr_micro_d  = ram_addr_micro_q;
    pronto_d          = 1'b0;
    jogada_ok_d       = 1'b0;
    jogada_invalida_d = 1'b0;
    jogador_vez_d     = jogador_vez_q;
    macro_livre_d     = macro_livre_q;
    macro_atual_d     = macro_atual_q;
    fim_jogo_d        = fim_jogo_q;
    vencedor_d        = vencedor_q;
    cnt_en            = 1'b0;

    case (state_q)
      LIMPA: begin
        cnt_en           = 1'b1;
        ram_we_d         = 1'b1;
        ram_addr_macro_d = cnt_macro;
        ram_addr_micro_d = cnt_micro;
        if (cnt_fim) begin
          state_d  = OCIOSO;
          pronto_d = 1'b1;
        end
      end
      OCIOSO: begin
        pronto_d = 1'b1;
        if (jogar) begin
          pronto_d  = 1'b0;
          macro_l_d = macro_in;
          micro_l_d = micro_in;
          jog_l_d   = jogador_vez_q;
          if (!pos_valida(macro_in) || !pos_valida(micro_in) ||
              (!macro_livre_q && macro_in != macro_atual_q)) begin
            state_d = REJEITA;
          end else begin
            state_d          = LE;
            ram_addr_macro_d = macro_in;
            ram_addr_micro_d = micro_in;
          end
        end
      end
      LE: state_d = CONFERE;
      CONFERE: begin
        if (ram_q != VAZIO || decidido(ram_state)) begin
          state_d = REJEITA;
        end else begin
          state_d    = ESCREVE;
          ram_we_d   = 1'b1;
          ram_data_d = jog_l_q;
        end
      end
      ESCREVE: state_d = ESPERA;
      ESPERA:  state_d = AMOSTRA_MICRO;
      AMOSTRA_MICRO: begin
        if (decidido(ram_state)) begin
          state_d          = ESCREVE_META;
          ram_we_d         = 1'b1;
          ram_data_d       = ram_state;
          ram_addr_macro_d = META_MACRO;
          ram_addr_micro_d = macro_l_q;
        end else begin
          state_d          = PROX_END;
          ram_addr_macro_d = micro_l_q;
        end
      end
      ESCREVE_META: state_d = ESPERA_META;
      ESPERA_META:  state_d = AMOSTRA_META;
      AMOSTRA_META: begin
        if (decidido(ram_state)) begin
          fim_jogo_d = 1'b1;
          vencedor_d = ram_state;
          state_d    = FIM;
        end else begin
          state_d          = PROX_END;
          ram_addr_macro_d = micro_l_q;
        end
      end
      PROX_END: state_d = PROX_AMOSTRA;
      PROX_AMOSTRA: begin
        macro_atual_d = micro_l_q;
        macro_livre_d = decidido(ram_state);
        state_d       = FIM;
      end
      FIM: begin
        jogada_ok_d   = 1'b1;
        jogador_vez_d = outro_jogador(jogador_vez_q);
        pronto_d      = 1'b1;
        state_d       = fim_jogo_q ? FIMJOGO : OCIOSO;
      end
      FIMJOGO: begin
        pronto_d          = 1'b1;
        jogada_invalida_d = jogar;
      end
      REJEITA: begin
        jogada_invalida_d = 1'b1;
        pronto_d          = 1'b1;
        state_d           = OCIOSO;
      end
      default: state_d = LIMPA;
    endcase

    // A new game aborts whatever is in flight; the sweep wipes any cell already written.
    if (iniciar) begin
      state_d           = LIMPA;
      ram_we_d          = 1'b0;
      ram_data_d        = VAZIO;
      ram_addr_macro_d  = 4'd0;
      ram_addr_micro_d  = 4'd0;
      pronto_d          = 1'b0;
      jogada_ok_d       = 1'b0;
      jogada_invalida_d = 1'b0;
      jogador_vez_d     = JOGADOR_INICIAL;
      macro_livre_d     = 1'b1;
      macro_atual_d     = 4'd0;
      fim_jogo_d        = 1'b0;
      vencedor_d        = VAZIO;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= LIMPA;
      macro_l_q         <= 4'd0;
      micro_l_q         <= 4'd0;
      jog_l_q           <= VAZIO;
      ram_we_q          <= 1'b0;
      ram_data_q        <= VAZIO;
      ram_addr_macro_q  <= 4'd0;
      ram_addr_micro_q  <= 4'd0;
      pronto_q          <= 1'b0;
      jogada_ok_q       <= 1'b0;
      jogada_invalida_q <= 1'b0;
      jogador_vez_q     <= JOGADOR_INICIAL;
      macro_livre_q     <= 1'b1;
      macro_atual_q     <= 4'd0;
      fim_jogo_q        <= 1'b0;
      vencedor_q        <= VAZIO;
    end else begin
      state_q           <= state_d;
      macro_l_q         <= macro_l_d;
      micro_l_q         <= micro_l_d;
      jog_l_q           <= jog_l_d;
      ram_we_q          <= ram_we_d;
      ram_data_q        <= ram_data_d;
      ram_addr_macro_q  <= ram_addr_macro_d;
      ram_addr_micro_q  <= ram_addr_micro_d;
      pronto_q          <= pronto_d;
      jogada_ok_q       <= jogada_ok_d;
      jogada_invalida_q <= jogada_invalida_d;
      jogador_vez_q     <= jogador_vez_d;
      macro_livre_q     <= macro_livre_d;
      macro_atual_q     <= macro_atual_d;
      fim_jogo_q        <= fim_jogo_d;
      vencedor_q        <= vencedor_d;
    end
  end

  assign ram_we          = ram_we_q;
  assign ram_data        = ram_data_q;
  assign ram_addr_macro  = ram_addr_macro_q;
  assign ram_addr_micro  = ram_addr_micro_q;
  assign pronto          = pronto_q;
  assign jogada_ok       = jogada_ok_q;
  assign jogada_invalida = jogada_invalida_q;
  assign jogador_vez     = jogador_vez_q;
  assign macro_livre     = macro_livre_q;
  assign macro_atual     = macro_atual_q;
  assign fim_jogo        = fim_jogo_q;
  assign vencedor        = vencedor_q;
endmodule

// File: doc/controle_jogada.md
Name: controle_jogada

Overview:
- Sequencer owning the single port of the 10x10x2 board RAM (ram_board) for an ultimate tic-tac-toe game.
- Clears the board, validates each move request, writes it, and reads back the sub-board winner.
- Records decided sub-boards in macro row 0 (the meta-board) and detects game end.
- Computes the macro cell the next player is forced into.
- Sits between the game UC/input logic and ram_board.

Parameters:
JOGADOR_INICIAL, 2'b01, player code that moves first after reset/iniciar
N_LIMPA, 100, number of sweep writes during clear (macro 0..9 x micro 0..9)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
iniciar  in  1  start new game (re-clear board); priority over jogar
jogar  in  1  move request, sampled only while pronto=1
macro_in  in  4  requested macro cell, valid 1..9
micro_in  in  4  requested micro cell, valid 1..9
ram_we  out  1  to ram_board.we
ram_data  out  2  to ram_board.data
ram_addr_macro  out  4  to ram_board.addr_macro
ram_addr_micro  out  4  to ram_board.addr_micro
ram_q  in  2  from ram_board.q (valid 1 cycle after address)
ram_state  in  2  from ram_board.state (valid 1 cycle after addr_macro held)
pronto  out  1  idle, ready to accept jogar
jogada_ok  out  1  1-cycle pulse: move committed
jogada_invalida  out  1  1-cycle pulse: move rejected, board unchanged
jogador_vez  out  2  player to move (01/10)
macro_livre  out  1  next move may target any undecided macro
macro_atual  out  4  forced macro when macro_livre=0
fim_jogo  out  1  game over
vencedor  out  2  meta-board result: 01, 10, 11 draw

Behaviour:
- Reset (async) values:
  - FSM to LIMPA, sweep counter 0.
  - pronto=0, jogada_ok=0, jogada_invalida=0, ram_we=0.
  - jogador_vez=JOGADOR_INICIAL, macro_livre=1, macro_atual=0, fim_jogo=0, vencedor=00.
- iniciar in any state: same as reset but synchronous. Aborts any move in progress; an already-written cell is cleared by the sweep.
- LIMPA: one write of 00 per cycle to (macro=cnt/10, micro=cnt%10), cnt 0..99, then OCIOSO. Takes exactly 100 cycles.
- OCIOSO: pronto=1. jogar is ignored whenever pronto=0. On jogar, latch macro_in, micro_in and jogador_vez, then:
  - macro or micro outside 1..9 -> REJEITA (jogada_invalida pulses 1 cycle after accept).
  - macro_livre=0 and macro_in != macro_atual -> REJEITA.
  - otherwise -> LE.
- LE: drive addr (macro, micro).
- CONFERE: ram_q != 00 or ram_state != 00 (sub-board already decided) -> REJEITA, else ESCREVE. Pulse arrives 3 cycles after accept.
- ESCREVE: we=1, data=player.
- ESPERA: addr held, we=0.
- AMOSTRA_MICRO: if ram_state != 00 -> ESCREVE_META, else PROX_END.
- ESCREVE_META: write ram_state to (0, macro). A drawn sub-board (11) counts for both players on the meta-board.
- ESPERA_META: addr held at macro 0.
- AMOSTRA_META:
  - ram_state != 00 -> fim_jogo=1, vencedor=ram_state, -> FIM.
  - else -> PROX_END.
- PROX_END: addr_macro=latched micro.
- PROX_AMOSTRA: macro_atual=micro; macro_livre=(ram_state != 00); -> FIM.
- FIM: jogada_ok pulse; jogador_vez toggles 01<->10. Then OCIOSO, or FIMJOGO if fim_jogo=1.
- Latency from accept edge to jogada_ok: 8 cycles with no sub-board decided; 11 with a sub-board decided.
- FIMJOGO: pronto=1; every jogar gives jogada_invalida the next cycle. Only iniciar/reset leaves this state.
- REJEITA: 1-cycle pulse, no write, player unchanged, -> OCIOSO.
- ram_we is asserted only in LIMPA, ESCREVE and ESCREVE_META.
- Addresses are always in range 0..9.

Decomposition:
- Package jogo_pkg:
  - player codes JOG1=2'b01, JOG2=2'b10, VAZIO=2'b00, EMPATE=2'b11.
  - META_MACRO=4'd0.
  - FSM state enum.
- Sub-module contador_limpeza: 0..99 counter with macro/micro split outputs and fim flag.

Test Plan:
- Reset then 100 cycles -> all 100 cells read 00; pronto=1 at cycle 100; jogador_vez=01, macro_livre=1.
- Move (5,3) by 01 -> jogada_ok 8 cycles after accept; cell(5,3)=01; jogador_vez=10, macro_livre=0, macro_atual=3.
- Next move (4,1) while macro_atual=3 -> jogada_invalida 1 cycle after accept; move (3,3) then (x,3) on the same cell -> invalida 3 cycles after accept; board unchanged.
- Player 01 fills micros 1,5,9 of macro 7 -> last jogada_ok after 11 cycles; cell(0,7)=01; a later move into macro 7 -> rejected.
- Forced macro already decided -> macro_livre=1 after that move; macro_in=0 or 10 -> invalida 1 cycle after accept.
- Meta-board line 01 at macros 1,2,3 -> fim_jogo=1, vencedor=01; further jogar -> invalida. iniciar mid-move (cycle 4) -> no jogada_ok; 100-cycle clear; cell zeroed; jogador_vez=01.
